// File: rtl/rom_rafaga.sv
// rom_rafaga: constant-table ROM that streams a burst of consecutive words
// over a valid/ready output.
//
// A request (inicio + direccion + longitud) is accepted only while idle. The
// block then presents one word per cycle while the consumer is ready. It stalls
// with every output held while the consumer is not ready.
//
// Output handshake: a beat transfers on every rising edge where
// valido_s & listo_s == 1. While valido_s is high and listo_s is low, dato_s,
// error_dir, ultimo_s and the internal address/counter do not change. valido_s
// never drops without a transfer, except on reset.
//
// Addressing: the address wraps to 0 after PROFUNDIDAD-1. Addresses at or
// above PROFUNDIDAD read as 0 and raise error_dir for that beat. They keep
// counting modulo 2^ANCHO_DIR, so they come back into range at 0.
//
// Optional build macro ROM_RAFAGA_PARIDAD_EN adds output paridad_s. It is the
// XOR of all bits of dato_s, registered alongside it, and 0 for out-of-range
// words.
//
// estado_fsm exposes the controller state: 0 = REPOSO, 1 = ENTREGA.

module rom_rafaga #(
    parameter int ANCHO_DATO  = 8,
    parameter int ANCHO_DIR   = 8,
    parameter int PROFUNDIDAD = 11,
    parameter int ANCHO_LON   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inicio,
    input  logic [ANCHO_DIR-1:0]  direccion,
    input  logic [ANCHO_LON-1:0]  longitud,
    input  logic                  listo_s,
    output logic [ANCHO_DATO-1:0] dato_s,
    output logic                  valido_s,
    output logic                  ultimo_s,
    output logic                  error_dir,
    output logic                  ocupado,
    output logic                  estado_fsm
`ifdef ROM_RAFAGA_PARIDAD_EN
    ,
    output logic                  paridad_s
`endif
);

    typedef enum logic {
        REPOSO  = 1'b0,
        ENTREGA = 1'b1
    } estado_t;

    // PROFUNDIDAD may equal 2^ANCHO_DIR, so the range limit needs one extra bit.
    localparam logic [ANCHO_DIR:0]   LIMITE     = PROFUNDIDAD[ANCHO_DIR:0];
    localparam logic [ANCHO_DIR-1:0] ULTIMA_DIR = ANCHO_DIR'(PROFUNDIDAD - 1);
    localparam logic [ANCHO_LON-1:0] CONT_UNO   = ANCHO_LON'(1);

    estado_t               estado;
    logic [ANCHO_DIR-1:0]  dir;
    logic [ANCHO_LON-1:0]  cont;

    logic                  carga;
    logic [ANCHO_DIR-1:0]  dir_sig;
    logic [ANCHO_DIR-1:0]  dir_carga;
    logic                  fuera_carga;
    logic [ANCHO_DATO-1:0] palabra_carga;

    // Table contents for an in-range index. Values are truncated to ANCHO_DATO.
    function automatic logic [ANCHO_DATO-1:0] contenido(input logic [ANCHO_DIR-1:0] d);
        int i;
        int v;
        i = int'(d);
        if (i <= 8) begin
            v = 90 - 10 * i;
        end else if (i == 9) begin
            v = 100;
        end else if (i == 10) begin
            v = 101;
        end else begin
            v = 0;
        end
        return ANCHO_DATO'(v);
    endfunction

    // True when the address is past the implemented words.
    function automatic logic fuera_rango(input logic [ANCHO_DIR-1:0] d);
        return ({1'b0, d} >= LIMITE);
    endfunction

    // Successor address. The wrap at the table end takes priority over the
    // natural modulo-2^ANCHO_DIR rollover used by out-of-range bursts.
    function automatic logic [ANCHO_DIR-1:0] siguiente(input logic [ANCHO_DIR-1:0] d);
        if (d == ULTIMA_DIR) begin
            return '0;
        end
        return d + 1'b1;
    endfunction

    // Decide whether this edge loads a word, and which word it loads.
    always_comb begin
        carga         = 1'b0;
        dir_sig       = siguiente(dir);
        dir_carga     = dir_sig;
        fuera_carga   = 1'b0;
        palabra_carga = '0;
        if (estado == REPOSO) begin
            dir_carga = direccion;
            carga     = inicio && (longitud != '0);
        end else begin
            carga = valido_s && listo_s && (cont != CONT_UNO);
        end
        fuera_carga = fuera_rango(dir_carga);
        if (!fuera_carga) begin
            palabra_carga = contenido(dir_carga);
        end
    end

    // Burst controller: accepts requests while idle, then walks the burst one
    // transferred beat at a time. All outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= REPOSO;
            dir       <= '0;
            cont      <= '0;
            dato_s    <= '0;
            error_dir <= 1'b0;
            valido_s  <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (carga) begin
                        dir       <= direccion;
                        cont      <= longitud;
                        dato_s    <= palabra_carga;
                        error_dir <= fuera_carga;
                        valido_s  <= 1'b1;
                        ocupado   <= 1'b1;
                        estado    <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    if (valido_s && listo_s) begin
                        if (cont == CONT_UNO) begin
                            // Last beat accepted: the burst is finished.
                            dato_s    <= '0;
                            error_dir <= 1'b0;
                            valido_s  <= 1'b0;
                            ocupado   <= 1'b0;
                            cont      <= '0;
                            estado    <= REPOSO;
                        end else begin
                            cont      <= cont - 1'b1;
                            dir       <= dir_sig;
                            dato_s    <= palabra_carga;
                            error_dir <= fuera_carga;
                        end
                    end
                end
                default: begin
                    estado   <= REPOSO;
                    valido_s <= 1'b0;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

    // Last-beat flag is derived from registered state, so it follows the stall.
    assign ultimo_s   = valido_s && (cont == CONT_UNO);
    assign estado_fsm = estado;

`ifdef ROM_RAFAGA_PARIDAD_EN
    // Parity of the word being loaded, kept in step with dato_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paridad_s <= 1'b0;
        end else if (carga) begin
            paridad_s <= ^palabra_carga;
        end else if (estado == ENTREGA && valido_s && listo_s) begin
            paridad_s <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/rom_rafaga.md
Name: rom_rafaga

Overview:
Parametrised, synchronous successor to the team's combinational lookup ROM.
- Contents are a fixed constant table.
- A request gives a start address and a length; the block streams that many consecutive words out on a valid/ready interface.
- The address wraps at the table depth, and out-of-range addresses are flagged.
- Sits between a sequencer/controller and any consumer that can stall, such as a display driver or an ALU operand feeder.

Parameters:
- ANCHO_DATO, 8, width of each stored word.
- ANCHO_DIR, 8, address width.
- PROFUNDIDAD, 11, number of implemented words (legal range 1..2^ANCHO_DIR).
- ANCHO_LON, 4, width of the burst-length field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- inicio  input  1  request strobe, sampled only in REPOSO.
- direccion  input  ANCHO_DIR  burst start address, sampled with inicio.
- longitud  input  ANCHO_LON  number of words in the burst (0 = no transfer).
- listo_s  input  1  consumer ready.
- dato_s  output  ANCHO_DATO  registered read data.
- valido_s  output  1  dato_s holds a valid word.
- ultimo_s  output  1  current word is the last word of the burst.
- error_dir  output  1  current word's address is >= PROFUNDIDAD.
- ocupado  output  1  a burst is in progress.

Behaviour:
- Reset (async, active-high): all outputs are 0, the FSM goes to REPOSO, and the internal address and counter are cleared. Reset mid-burst aborts it immediately; there is no completion beat.
- Contents: word i = 90 - 10*i for i = 0..8, word 9 = 100, word 10 = 101. Words 11..PROFUNDIDAD-1 = 0. Each value is truncated to ANCHO_DATO bits.
- FSM state REPOSO:
  - ocupado = 0, valido_s = 0.
  - inicio=1 with longitud!=0: capture dir=direccion and cont=longitud, and load dato_s/error_dir for dir. Set valido_s=1 and ocupado=1, then go to ENTREGA.
  - Latency: the first word is visible in the cycle after inicio.
  - inicio=1 with longitud=0: ignored, no output, stay in REPOSO.
- FSM state ENTREGA:
  - A beat transfers on any edge where valido_s & listo_s = 1.
  - On transfer with cont==1: valido_s=0, ocupado=0, go to REPOSO.
  - On transfer with cont>1: cont--, advance dir, and load the next word in the same edge. This sustains one word per cycle with listo_s held high.
  - With valido_s=1 and listo_s=0: dato_s, error_dir, ultimo_s, dir and cont all hold.
- ultimo_s = valido_s & (cont==1), combinational from registered state.
- Address advance:
  - If dir == PROFUNDIDAD-1, the next dir is 0 (wrap).
  - Otherwise dir+1, modulo 2^ANCHO_DIR.
- Out of range:
  - dir >= PROFUNDIDAD gives dato_s = 0 and error_dir = 1 for that beat only.
  - Such a burst keeps incrementing normally, modulo 2^ANCHO_DIR. It wraps to 0 at 2^ANCHO_DIR and becomes in range again.
- inicio while ocupado=1 is ignored: no queueing, no effect on the current burst.
- No back-to-back bursts: at least one REPOSO cycle between bursts.
- Back-to-back throughput within a burst is 1 word/cycle.
- Maximum burst length is 2^ANCHO_LON - 1.

Optional Feature:
- Macro: ROM_RAFAGA_PARIDAD_EN.
- When defined:
  - Adds output port paridad_s, 1 bit.
  - paridad_s is the even-parity bit (XOR of all bits) of dato_s.
  - It is registered together with dato_s, reset to 0, and held under stall.
  - An out-of-range word gives paridad_s = 0.
- When undefined: the port is absent and the behaviour is otherwise identical.

Test Plan:
All scenarios use default parameters.
1. Basic burst: direccion=2, longitud=3, listo_s=1.
   - Required: dato_s = 70, 60, 50 on three consecutive cycles starting the cycle after inicio.
   - ultimo_s=1 only with 50; valido_s and ocupado drop the following cycle.
2. Wrap: direccion=9, longitud=4, listo_s=1.
   - Required: 100, 101, 90, 80, with error_dir=0 throughout.
3. Backpressure: direccion=0, longitud=2, listo_s=0 for 3 cycles, then 1.
   - Required: dato_s=90 and valido_s=1 held stable for 3 cycles, then 90 transfers, then 80 with ultimo_s=1.
4. Out of range: direccion=200, longitud=2.
   - Required: dato_s=0, 0 with error_dir=1 on both beats.
   - Also direccion=255, longitud=2 gives 0 (error_dir=1) then 90 (error_dir=0).
5. Ignored requests:
   - longitud=0 gives no valido_s and ocupado stays 0.
   - inicio pulsed at the second beat of a direccion=4, longitud=3 burst gives 50, 40, 30 unchanged.
6. Reset and parity:
   - rst asserted between edges during the second beat of a burst gives all outputs 0 immediately, and the FSM is in REPOSO after release.
   - With ROM_RAFAGA_PARIDAD_EN, paridad_s = 0 for 90 (01011010) and 1 for 70 (01000110).
